// File: rtl/comp_adder_16bits.sv
// 16-bit adder/subtractor with conditional b inversion, carry-out and carry-into-MSB.
// Four 4-bit carry-lookahead groups rippled together; optional registered outputs.
module comp_adder_16bits #(
    parameter int unsigned REG_OUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        sign,
    input  logic        comp_e,
    output logic [15:0] s,
    output logic        cout,
    output logic        cout_1
);

    logic [15:0] b_eff;
    logic        cin_eff;
    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [15:0] sum_d;
    logic [15:0] s_q;
    logic        cout_q;
    logic        cout_1_q;

    assign b_eff   = b ^ {16{sign}};
    // cin is ignored entirely in two's-complement mode so an X there cannot leak.
    assign cin_eff = comp_e ? sign : cin;
    assign gen     = a & b_eff;
    assign prop    = a ^ b_eff;

    always_comb begin
        carry    = '0;
        grp_g    = '0;
        grp_p    = '0;
        carry[0] = cin_eff;
        for (int k = 0; k < 4; k++) begin
            carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
            carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
            grp_g[k]     = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                         | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            grp_p[k]     = &prop[4*k +: 4];
            carry[4*k+4] = grp_g[k] | (grp_p[k] & carry[4*k]);
        end
    end

    assign sum_d = prop ^ carry[15:0];

    // Registers always exist; with REG_OUT=0 they are unloaded and trimmed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            cout_q   <= 1'b0;
            cout_1_q <= 1'b0;
        end else begin
            s_q      <= sum_d;
            cout_q   <= carry[16];
            cout_1_q <= carry[15];
        end
    end

    assign s      = (REG_OUT != 0) ? s_q      : sum_d;
    assign cout   = (REG_OUT != 0) ? cout_q   : carry[16];
    assign cout_1 = (REG_OUT != 0) ? cout_1_q : carry[15];

endmodule

// File: tb/tb_comp_adder_16bits.sv
// Bench for comp_adder_16bits: combinational and registered instances driven in parallel,
// directed vector table, random vectors against a reference equation, reset sequences.
module tb_comp_adder_16bits;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sign;
    logic        comp_e;
    logic [15:0] s_c;
    logic        cout_c;
    logic        cout_1_c;
    logic [15:0] s_r;
    logic        cout_r;
    logic        cout_1_r;

    int checks = 0;
    int errors = 0;

    logic [17:0] sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sign;
        logic        comp_e;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        cout_1;
    } vec_t;

    vec_t vecs[9];

    comp_adder_16bits #(.REG_OUT(0)) u_comb (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sign   (sign),
        .comp_e (comp_e),
        .s      (s_c),
        .cout   (cout_c),
        .cout_1 (cout_1_c)
    );

    comp_adder_16bits #(.REG_OUT(1)) u_reg (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sign   (sign),
        .comp_e (comp_e),
        .s      (s_r),
        .cout   (cout_r),
        .cout_1 (cout_1_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packed as {cout, cout_1, s}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms, input logic mcin, input logic mce);
        logic [15:0] bx;
        logic        ci;
        logic [16:0] s17;
        logic [15:0] c14;
        bx  = mb ^ {16{ms}};
        ci  = mce ? ms : mcin;
        s17 = {1'b0, ma} + {1'b0, bx} + 17'(ci);
        c14 = {1'b0, ma[14:0]} + {1'b0, bx[14:0]} + 16'(ci);
        return {s17[16], c14[15], s17[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got s=%h cout=%b cout_1=%b, want s=%h cout=%b cout_1=%b",
                     nm, act[15:0], act[17], act[16], exp[15:0], exp[17], exp[16]);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input logic vce, input logic vcin);
        a      = va;
        b      = vb;
        sign   = vs;
        comp_e = vce;
        cin    = vcin;
    endtask

    // Drive on a falling edge, hold 20 ns (two rising edges), compare both instances.
    task automatic apply(input string nm, input logic [15:0] va, input logic [15:0] vb,
                         input logic vs, input logic vce, input logic vcin,
                         input logic [17:0] exp);
        logic [17:0] e;
        @(negedge clk);
        drive(va, vb, vs, vce, vcin);
        sb.push_back(exp);
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({nm, "_comb"}, {cout_c, cout_1_c, s_c}, e);
        chk({nm, "_reg"}, {cout_r, cout_1_r, s_r}, e);
    endtask

    initial begin
        logic [17:0] e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rc;

        vecs[0] = '{16'h1234, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h1236, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h0010, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1;
        drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_state_reg", {cout_r, cout_1_r, s_r}, 18'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sign,
                  vecs[i].comp_e, vecs[i].cin, {vecs[i].cout, vecs[i].cout_1, vecs[i].s});
        end

        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 3'($urandom);
            apply("rand", ra, rb, rc[0], rc[1], rc[2], model(ra, rb, rc[0], rc[2], rc[1]));
        end

        // Load a nonzero result with both carries set, then reset between clock edges.
        apply("pre_reset", 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0001});
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_reg", {cout_r, cout_1_r, s_r}, 18'h0);
        chk("async_reset_comb", {cout_c, cout_1_c, s_c}, {1'b1, 1'b1, 16'h0001});
        @(posedge clk);
        #1;
        chk("reset_held_reg", {cout_r, cout_1_r, s_r}, 18'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
        sb.push_back({1'b0, 1'b0, 16'h0007});
        #1;
        chk("latency_before_edge", {cout_r, cout_1_r, s_r}, 18'h0);
        chk("latency_comb", {cout_c, cout_1_c, s_c}, {1'b0, 1'b0, 16'h0007});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("latency_after_edge", {cout_r, cout_1_r, s_r}, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_adder_16bits.md
Name: comp_adder_16bits

Overview:
- 16-bit adder/subtractor for the datapath ALU.
- Conditionally inverts operand b, so the same hardware performs add, two's-complement subtract, or add-with-inverted-b plus external carry.
- Provides carry-out and carry-into-MSB (cout_1), so downstream logic can derive signed overflow as cout ^ cout_1.
- Default build is purely combinational; an optional output register stage uses the block clock/reset.

Parameters:
- REG_OUT, 0, 0 = s/cout/cout_1 combinational from inputs (zero latency); 1 = outputs registered on rising clk (1-cycle latency).

Ports:
- clk  input  1  block clock; only used when REG_OUT=1.
- rst  input  1  asynchronous, active-high reset; only affects the output registers when REG_OUT=1.
- a  input  16  operand A, unsigned/two's-complement bit pattern.
- b  input  16  operand B.
- cin  input  1  external carry-in; used only when comp_e=0.
- sign  input  1  1 = invert b (subtract mode), 0 = pass b.
- comp_e  input  1  1 = carry-in forced to sign (true two's complement); 0 = carry-in taken from cin.
- s  output  16  sum bits [15:0].
- cout  output  1  carry out of bit 15.
- cout_1  output  1  carry out of bit 14, i.e. carry into bit 15.

Behaviour:
- b_eff = b XOR {16{sign}}.
- cin_eff = comp_e ? sign : cin.
- sum17 = {1'b0,a} + {1'b0,b_eff} + cin_eff (17-bit, no truncation before compare).
- s = sum17[15:0]; cout = sum17[16].
- cout_1 = carry generated out of bit position 14 of the same addition, equivalently ({1'b0,a[14:0]} + {1'b0,b_eff[14:0]} + cin_eff)[15].
- Signed overflow (not an output) = cout ^ cout_1.
- Mode summary:
  - sign=0: a+b+cin_eff.
  - sign=1, comp_e=1: a-b (two's complement); cout=1 means no borrow.
  - sign=1, comp_e=0: a+~b+cin.
- Wrap-around: results are modulo 2^16 and the carry is reported in cout; there is no saturation.
- Structure: four 4-bit carry-lookahead groups (per-bit generate/propagate, group G/P) with ripple between groups. Group-3 internal carry c15 is exported as cout_1. Any structure meeting the equations is acceptable.
- REG_OUT=0:
  - Outputs settle combinationally; no state.
  - clk/rst are ignored.
  - Outputs must be valid within 20 ns of any input change.
- REG_OUT=1:
  - s, cout, cout_1 are captured on each rising clk from the combinational result; 1-cycle latency, no enable.
  - rst=1 asynchronously forces s=16'h0000, cout=0, cout_1=0, held while rst is high.
  - The first capture occurs at the first rising clk after rst deasserts.
  - Reset mid-operation discards the in-flight result.
- No X propagation from unused inputs: cin is don't-care when comp_e=1 and must not affect outputs.

Test Plan:
- Add: a=16'h1234, b=16'h0001, sign=0, comp_e=0, cin=1 -> s=16'h1236, cout=0, cout_1=0.
- Subtract: a=16'h0005, b=16'h0007, sign=1, comp_e=1, cin=0 -> s=16'hFFFE, cout=0 (borrow). Then a=16'h0007, b=16'h0005 -> s=16'h0002, cout=1.
- Unsigned wrap: a=16'hFFFF, b=16'h0001, sign=0, comp_e=1 -> s=16'h0000, cout=1, cout_1=1. Signed overflow: a=16'h7FFF, b=16'h0001, sign=0, cin=0, comp_e=0 -> s=16'h8000, cout=0, cout_1=1.
- Inverted-b with external carry: a=16'h0010, b=16'h0010, sign=1, comp_e=0, cin=0 -> s=16'hFFFF, cout=0; same with cin=1 -> s=16'h0000, cout=1. Also check cin toggling with comp_e=1 leaves outputs unchanged.
- Random: 400 vectors of random a, b, sign, cin, comp_e; wait 20 ns per vector; compare s/cout against the 17-bit reference equation and cout_1 against the bit-14 carry -> zero mismatches.
- REG_OUT=1:
  - Assert rst mid-stream -> outputs go to 0 immediately, without a clock edge.
  - Release rst, apply a=16'h0003, b=16'h0004, sign=0, cin=0 -> s=16'h0007 appears after the next rising clk and not before.
